ula_acc: RTL

- Sequential accumulator front-end for the 2-bit-opcode signed ALU.
- Accepts operation commands over a valid/ready handshake and uses its accumulator register as operand A.
- Executes one ALU operation per command, writes the result back to the accumulator and returns the result plus overflow over a valid/ready response port.
- Sits between the switch/command logic and the display/result logic of the lab datapath.

---
 rtl/ula_pkg.sv | 35 +++
 rtl/ula_core.sv | 42 ++++
 rtl/ula_acc.sv | 92 +++++++++
 3 files changed

// File: rtl/ula_pkg.sv
// ula_pkg: widths, opcodes, FSM states, command/response records and
// saturation limits shared by the ula_acc accumulator and its ula_core ALU.
package ula_pkg;

  localparam int X = 2;
  localparam int Y = 8;

  localparam logic [Y-1:0] SAT_MAX = {1'b0, {(Y-1){1'b1}}};
  localparam logic [Y-1:0] SAT_MIN = {1'b1, {(Y-1){1'b0}}};

  typedef enum logic [X-1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_ADD = 2'b10,
    OP_SUB = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESP
  } state_t;

  typedef struct packed {
    logic         load;
    op_t          f;
    logic [Y-1:0] b;
  } cmd_t;

  // An arithmetic overflow always has the sign of operand A as its true sign.
  function automatic logic [Y-1:0] clamp(input logic neg);
    return neg ? SAT_MIN : SAT_MAX;
  endfunction

endpackage

// File: rtl/ula_core.sv
// ula_core: 2-bit-opcode signed ALU (AND, OR, ADD, SUB) with sign-bit overflow.
// Latency: purely combinational, zero cycles.
// Backpressure: none, result follows the inputs.
module ula_core
  import ula_pkg::*;
(
  input  op_t          f,
  input  logic [Y-1:0] a,
  input  logic [Y-1:0] b,
  output logic [Y-1:0] result,
  output logic         overflow
);

  logic [Y-1:0] sum;
  logic [Y-1:0] diff;

  assign sum  = a + b;
  assign diff = a - b;

  // Sign bits only, so a zero operand (e.g. 0 - MIN) is still caught.
  always_comb begin
    result   = '0;
    overflow = 1'b0;
    case (f)
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_ADD: begin
        result   = sum;
        overflow = (a[Y-1] == b[Y-1]) && (sum[Y-1] != a[Y-1]);
      end
      OP_SUB: begin
        result   = diff;
        overflow = (a[Y-1] != b[Y-1]) && (diff[Y-1] != a[Y-1]);
      end
      default: begin
        result   = '0;
        overflow = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/ula_acc.sv
// ula_acc: command-driven accumulator around ula_core; ULA_ACC_SATURATE_EN clamps ADD/SUB overflow.
// Latency: response valid two cycles after the accepting cycle; one op per 3 cycles.
// Backpressure: one command in flight, cmd_ready low until the response is taken.
module ula_acc
  import ula_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic         cmd_load,
  input  logic [X-1:0] cmd_f,
  input  logic [Y-1:0] cmd_b,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic [Y-1:0] resp_res,
  output logic         resp_ovf,
  output logic         ovf_sticky,
  output logic [Y-1:0] acc
);

  state_t       state;
  cmd_t         cmd_q;
  logic [Y-1:0] core_res;
  logic         core_ovf;
  logic [Y-1:0] exec_res;

  ula_core u_core (
    .f        (cmd_q.f),
    .a        (acc),
    .b        (cmd_q.b),
    .result   (core_res),
    .overflow (core_ovf)
  );

`ifdef ULA_ACC_SATURATE_EN
  assign exec_res = core_ovf ? clamp(acc[Y-1]) : core_res;
`else
  assign exec_res = core_res;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cmd_q      <= '0;
      acc        <= '0;
      resp_res   <= '0;
      resp_ovf   <= 1'b0;
      ovf_sticky <= 1'b0;
      resp_valid <= 1'b0;
      cmd_ready  <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            cmd_q     <= '{load: cmd_load, f: op_t'(cmd_f), b: cmd_b};
            cmd_ready <= 1'b0;
            state     <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (cmd_q.load) begin
            acc        <= cmd_q.b;
            resp_res   <= cmd_q.b;
            resp_ovf   <= 1'b0;
            ovf_sticky <= 1'b0;
          end else begin
            acc        <= exec_res;
            resp_res   <= exec_res;
            resp_ovf   <= core_ovf;
            ovf_sticky <= ovf_sticky | core_ovf;
          end
          resp_valid <= 1'b1;
          state      <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            cmd_ready  <= 1'b1;
            state      <= S_IDLE;
          end
        end
        default: begin
          resp_valid <= 1'b0;
          cmd_ready  <= 1'b1;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule
